dram_arbiter: RTL and testbench
===============================

# dram_arbiter

Round-robin arbiter that shares one single-port, synchronous-read DRAM (8-bit address, 8-bit data, `wren`, registered address, `q` valid one cycle after the address edge) between `NCORES` processor cores. It sits between each core's `TopRegisterWrapper` data-memory port and the `DRAM` instance. It serialises accesses, pulses a grant to the winning core and returns read data with a one-hot valid strobe. All logic runs on the divided processor clock.

## Interface
Parameters:
- `NCORES`, 4: number of requesting cores (2..8).
- `AW`, 8: address width.
- `DW`, 8: data width.

Ports:
- `CLK`  in  1  processor clock (divided clock); the single clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  NCORES  per-core access request, level.
- `we`  in  NCORES  per-core write enable (1 = write, 0 = read), qualified by `req`.
- `addr`  in  NCORES*AW  per-core address; core i at bits [i*AW +: AW].
- `wdata`  in  NCORES*DW  per-core write data; same packing.
- `gnt`  out  NCORES  one-hot, one-cycle pulse: the winner's access is on the memory port this cycle.
- `rdata`  out  DW  read data, broadcast to all cores.
- `rvalid`  out  NCORES  one-hot, one-cycle pulse: `rdata` belongs to core i.
- `mem_addr`  out  AW  to DRAM `address`.
- `mem_data`  out  DW  to DRAM `data`.
- `mem_wren`  out  1  to DRAM `wren`.
- `mem_q`  in  DW  from DRAM `q`.

## Operation
- States: IDLE, ISSUE, RWAIT, RDONE.
- IDLE: if any `req` is set, the round-robin picker selects the winner `w`, searching upward from `last+1` mod NCORES. The FSM registers `w`, `addr[w]`, `wdata[w]` and `we[w]` into `mem_addr`, `mem_data` and the latched `we_q`, then moves to ISSUE. With no request it stays in IDLE.
- ISSUE: `gnt[w]`=1 and `mem_wren`=`we_q`; `last` <= `w`.
  - Write: next state is IDLE.
  - Read: next state is RWAIT.
- RWAIT: `mem_q` becomes valid during this cycle. `rdata` <= `mem_q` at the end of the cycle. Next state is RDONE.
- RDONE: `rvalid[w]`=1 with `rdata` stable. Next state is IDLE.
- `mem_wren` is 1 only in ISSUE with `we_q`=1; it is 0 in every other state.
- `gnt`, `rvalid` and `mem_wren` are registered and glitch-free.
- `mem_addr` and `mem_data` hold their last value outside ISSUE.
- `rdata` holds its value until the next read completes.
- Requesters hold `req`/`we`/`addr`/`wdata` until they see their `gnt`, then deassert `req` in the cycle after `gnt` or issue a new access.
- If the winner drops `req` between selection and ISSUE, the registered access is still performed and granted.
- A request arriving during ISSUE, RWAIT or RDONE waits for IDLE.
- Simultaneous requests: strict rotation. A core that was just served has the lowest priority next time, so no starvation; the worst-case wait is NCORES-1 accesses.
- Reset (async, `rst`=0): state IDLE, `last`=NCORES-1 (core 0 wins first). `gnt`, `rvalid`, `mem_wren`, `mem_addr`, `mem_data` and `rdata` all reset to 0.
- Reset asserted mid-access aborts it: no `rvalid` is produced, and the write is not performed if reset hits before the ISSUE edge.

## Timing
- Cycle 0 is the IDLE cycle in which `req` is sampled.
- Write: `gnt` and `mem_wren` in cycle 1; memory is written at the end of cycle 1; back in IDLE in cycle 2.
  - Write occupancy: 2 cycles.
- Read: `gnt` in cycle 1; `mem_q` valid in cycle 2; `rvalid`/`rdata` in cycle 3; IDLE in cycle 4.
  - Read occupancy: 4 cycles.
- Sustained write throughput: one write per 2 cycles.
- No combinational path exists from any input to any output.

## Structure
- Shared `define.v` gains these constants:
  - state encodings `ARB_IDLE`, `ARB_ISSUE`, `ARB_RWAIT`, `ARB_RDONE` (2-bit);
  - `ARB_NCORES` default.
- Sub-module `rr_picker`: purely combinational rotating-priority encoder.
  - Inputs: `req` and `last`.
  - Outputs: one-hot `pick` and `any`.
  - Reusable for a later IRAM arbiter.
- Top-level multi-core `Processor` variant instantiates one `dram_arbiter` in front of `DRAM1`.
- Estimated size: about 180 RTL lines including the picker.

## Test plan
- Reset, then single write from core 2 (addr 8'h10, data 8'hA5), then read from core 2 at 8'h10 -> write: `gnt`=4'b0100 in cycle 1 with `mem_wren`=1. Read: `rvalid`=4'b0100 with `rdata`=8'hA5 three cycles after `req`.
- All four cores assert write requests simultaneously after reset, each to a distinct address -> grants in order cores 0,1,2,3, spaced 2 cycles apart. Readback of all four returns the correct data.
- Core 0 requests continuously while core 3 requests once -> after core 0's grant, core 3 is granted next. Core 0 is never granted twice in a row while core 3 is pending.
- Read in flight (state RWAIT) while core 1 raises a write -> core 1's `gnt` does not appear until after RDONE. `mem_wren` is never 1 during RWAIT or RDONE.
- Assert `rst` low during RWAIT of a core 2 read -> all outputs 0 immediately and no `rvalid` pulse. After release, core 0 wins the first contested cycle.
- Winner drops `req` in the cycle after selection -> `gnt` still pulses once and the access completes. No second grant is issued to that core.

Source files
------------

// File: rtl/dram_arbiter_pkg.sv
// rtl/dram_arbiter_pkg.sv - shared constants and FSM state encoding for the DRAM arbiter
package dram_arbiter_pkg;

  localparam int ARB_NCORES = 4;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_RWAIT = 2'd2,
    ARB_RDONE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/dram_arbiter_rr_picker.sv
// rtl/dram_arbiter_rr_picker.sv - combinational rotating-priority picker, searches upward from last+1
module rr_picker #(
  parameter int N  = 4,
  parameter int LW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [N-1:0]  pick,
  output logic          any
);

  // Walk from the farthest candidate to the nearest so the closest request after last wins.
  always_comb begin
    pick = '0;
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(last) + k) % N]) begin
        pick = '0;
        pick[(int'(last) + k) % N] = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - round-robin arbiter sharing one synchronous-read DRAM between NCORES cores
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int NCORES = ARB_NCORES,
  parameter int AW     = 8,
  parameter int DW     = 8
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic [NCORES-1:0]    req,
  input  logic [NCORES-1:0]    we,
  input  logic [NCORES*AW-1:0] addr,
  input  logic [NCORES*DW-1:0] wdata,
  output logic [NCORES-1:0]    gnt,
  output logic [DW-1:0]        rdata,
  output logic [NCORES-1:0]    rvalid,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_data,
  output logic                 mem_wren,
  input  logic [DW-1:0]        mem_q
);

  localparam int LW = $clog2(NCORES);

  arb_state_t        state;
  logic [LW-1:0]     last;
  logic [LW-1:0]     win;
  logic [LW-1:0]     pick_idx;
  logic [NCORES-1:0] pick;
  logic              any;
  logic              we_q;

  rr_picker #(.N(NCORES), .LW(LW)) u_picker (
    .req  (req),
    .last (last),
    .pick (pick),
    .any  (any)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NCORES; i++) begin
      if (pick[i]) pick_idx = LW'(i);
    end
  end

  // gnt/mem_wren are loaded on the IDLE->ISSUE edge so they are high exactly during ISSUE.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state    <= ARB_IDLE;
      last     <= LW'(NCORES - 1);
      win      <= '0;
      we_q     <= 1'b0;
      gnt      <= '0;
      rvalid   <= '0;
      mem_wren <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      rdata    <= '0;
    end else begin
      gnt      <= '0;
      rvalid   <= '0;
      mem_wren <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (any) begin
            win      <= pick_idx;
            mem_addr <= addr[pick_idx*AW +: AW];
            mem_data <= wdata[pick_idx*DW +: DW];
            we_q     <= we[pick_idx];
            gnt      <= pick;
            mem_wren <= we[pick_idx];
            state    <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          last  <= win;
          state <= we_q ? ARB_IDLE : ARB_RWAIT;
        end
        ARB_RWAIT: begin
          rdata  <= mem_q;
          rvalid <= {{(NCORES-1){1'b0}}, 1'b1} << win;
          state  <= ARB_RDONE;
        end
        ARB_RDONE: state <= ARB_IDLE;
        default:   state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// tb/tb_dram_arbiter.sv - scoreboard bench for dram_arbiter with a synchronous-read DRAM model
module tb_dram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req, we, gnt, rvalid;
  logic [31:0] addr, wdata;
  logic [7:0]  rdata, mem_addr, mem_data, mem_q;
  logic        mem_wren;
  logic [7:0]  ram [0:255];

  typedef struct { int core; bit wr; logic [7:0] a; logic [7:0] d; int gap; } gexp_t;
  typedef struct { int core; logic [7:0] d; } rexp_t;

  gexp_t gnt_q[$];
  rexp_t rd_q[$];
  int n_chk = 0, n_fail = 0, cyc = 0, last_gnt = 0, took;

  dram_arbiter #(.NCORES(4), .AW(8), .DW(8)) dut (
    .CLK(clk), .rst(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rdata(rdata), .rvalid(rvalid), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wren) ram[mem_addr] <= mem_data;
    mem_q <= ram[mem_addr];
  end

  always @(negedge clk) begin
    gexp_t ge;
    rexp_t re;
    logic [3:0] oh;
    cyc++;
    if (rst_n) begin
      n_chk++;
      if (mem_wren && gnt == 4'b0) begin
        n_fail++;
        $display("FAIL wren_without_gnt: mem_wren=1 gnt=%b, required mem_wren=0", gnt);
      end
      if (gnt != 4'b0) begin
        n_chk++;
        if (gnt_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_gnt: got gnt=%b, required no grant", gnt);
        end else begin
          ge = gnt_q.pop_front();
          oh = 4'b1 << ge.core;
          if (gnt !== oh || mem_wren !== ge.wr || mem_addr !== ge.a ||
              (ge.wr && mem_data !== ge.d) || (ge.gap != 0 && cyc - last_gnt != ge.gap)) begin
            n_fail++;
            $display("FAIL grant: got gnt=%b wren=%b addr=%h data=%h gap=%0d, required gnt=%b wren=%b addr=%h data=%h gap=%0d",
                     gnt, mem_wren, mem_addr, mem_data, cyc - last_gnt, oh, ge.wr, ge.a, ge.d, ge.gap);
          end
        end
        last_gnt = cyc;
      end
      if (rvalid != 4'b0) begin
        n_chk++;
        if (rd_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_rvalid: got rvalid=%b, required none", rvalid);
        end else begin
          re = rd_q.pop_front();
          oh = 4'b1 << re.core;
          if (rvalid !== oh || rdata !== re.d || cyc - last_gnt != 2) begin
            n_fail++;
            $display("FAIL read: got rvalid=%b rdata=%h gnt_to_rvalid=%0d, required rvalid=%b rdata=%h gnt_to_rvalid=2",
                     rvalid, rdata, cyc - last_gnt, oh, re.d);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic exp_gnt(input int core, input bit wr, input logic [7:0] a, input logic [7:0] d, input int gap);
    gexp_t g;
    g.core = core; g.wr = wr; g.a = a; g.d = d; g.gap = gap;
    gnt_q.push_back(g);
  endtask

  task automatic exp_rd(input int core, input logic [7:0] d);
    rexp_t r;
    r.core = core; r.d = d;
    rd_q.push_back(r);
  endtask

  task automatic set_core(input int i, input logic w, input logic [7:0] a, input logic [7:0] d);
    req[i] = 1'b1;
    we[i]  = w;
    addr[i*8 +: 8]  = a;
    wdata[i*8 +: 8] = d;
  endtask

  task automatic wait_grants(input logic [3:0] mask, input logic [3:0] sticky, input int budget, output int n);
    logic [3:0] pend;
    pend = mask;
    n = 0;
    while (pend != 4'b0 && n < budget) begin
      @(negedge clk);
      n++;
      for (int i = 0; i < 4; i++) if (gnt[i] && !sticky[i]) req[i] = 1'b0;
      pend &= ~gnt;
    end
    n_chk++;
    if (pend != 4'b0) begin
      n_fail++;
      $display("FAIL grant_timeout: pending=%b after %0d cycles, required 0000", pend, n);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((gnt_q.size() != 0 || rd_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check("scoreboard_empty", gnt_q.size() + rd_q.size(), 0);
  endtask

  task automatic do_reset();
    req = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, gnt, 0);
    check({tag, "_rvalid"}, rvalid, 0);
    check({tag, "_wren"}, mem_wren, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_data"}, mem_data, 0);
    check({tag, "_rdata"}, rdata, 0);
  endtask

  initial begin
    req = '0; we = '0; addr = '0; wdata = '0; rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // single write then read from core 2
    exp_gnt(2, 1'b1, 8'h10, 8'hA5, 0);
    set_core(2, 1'b1, 8'h10, 8'hA5);
    wait_grants(4'b0100, 4'b0000, 20, took);
    check("t1_write_latency", took, 1);
    drain(20);
    exp_gnt(2, 1'b0, 8'h10, 8'h00, 0);
    exp_rd(2, 8'hA5);
    set_core(2, 1'b0, 8'h10, 8'h00);
    wait_grants(4'b0100, 4'b0000, 20, took);
    check("t1_read_latency", took, 1);
    drain(20);

    // four simultaneous writes, then four simultaneous reads
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_gnt(i, 1'b1, 8'h20 + 8'(i), 8'h31 + 8'(i * 17), (i == 0) ? 0 : 2);
      set_core(i, 1'b1, 8'h20 + 8'(i), 8'h31 + 8'(i * 17));
    end
    wait_grants(4'b1111, 4'b0000, 30, took);
    drain(20);
    for (int i = 0; i < 4; i++) begin
      exp_gnt(i, 1'b0, 8'h20 + 8'(i), 8'h00, (i == 0) ? 0 : 4);
      exp_rd(i, 8'h31 + 8'(i * 17));
      set_core(i, 1'b0, 8'h20 + 8'(i), 8'h00);
    end
    wait_grants(4'b1111, 4'b0000, 40, took);
    drain(20);

    // core 0 requests continuously, core 3 once
    do_reset();
    exp_gnt(0, 1'b1, 8'h30, 8'h77, 0);
    exp_gnt(3, 1'b1, 8'h33, 8'h88, 2);
    set_core(0, 1'b1, 8'h30, 8'h77);
    set_core(3, 1'b1, 8'h33, 8'h88);
    wait_grants(4'b1000, 4'b0001, 20, took);
    req[0] = 1'b0;
    drain(20);

    // core 1 write raised while core 2 read is in flight
    exp_gnt(2, 1'b0, 8'h22, 8'h00, 0);
    exp_rd(2, 8'h53);
    exp_gnt(1, 1'b1, 8'h40, 8'h9C, 4);
    set_core(2, 1'b0, 8'h22, 8'h00);
    wait_grants(4'b0100, 4'b0000, 20, took);
    set_core(1, 1'b1, 8'h40, 8'h9C);
    wait_grants(4'b0010, 4'b0000, 20, took);
    drain(20);

    // winner drops req right after being selected
    exp_gnt(1, 1'b0, 8'h40, 8'h00, 0);
    exp_rd(1, 8'h9C);
    set_core(1, 1'b0, 8'h40, 8'h00);
    @(posedge clk);
    #1 req[1] = 1'b0;
    drain(20);

    // reset during RWAIT of a core 2 read
    exp_gnt(2, 1'b0, 8'h10, 8'h00, 0);
    set_core(2, 1'b0, 8'h10, 8'h00);
    wait_grants(4'b0100, 4'b0000, 20, took);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midread_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_gnt(0, 1'b1, 8'h50, 8'h5A, 0);
    exp_gnt(3, 1'b1, 8'h60, 8'h6B, 2);
    set_core(0, 1'b1, 8'h50, 8'h5A);
    set_core(3, 1'b1, 8'h60, 8'h6B);
    wait_grants(4'b1001, 4'b0000, 20, took);
    drain(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
